// File: rtl/conversor_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package conversor_pkg;

   typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} estado_t;

   localparam int unsigned N_DIGITOS   = 3;
   localparam int unsigned LARGURA_MAX = 9;

   typedef logic [3:0] digito_t;

endpackage

// File: rtl/ajuste_bcd_digito.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more.
module ajuste_bcd_digito
   import conversor_pkg::*;
(
   input  digito_t entrada,
   output digito_t saida
);

   assign saida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Multi-cycle shift-add-3 binary-to-BCD converter with start/done handshake.
// Optional signed operand support is enabled with the CONV_SINAL_EN macro.
module conversor_bcd_sequencial
   import conversor_pkg::*;
#(
   parameter int unsigned LARGURA = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inicio,
   input  logic [LARGURA-1:0] valor_binario,
   output logic               ocupado,
   output logic               pronto,
   output digito_t            centena_out,
   output digito_t            dezena_out,
   output digito_t            unidade_out
`ifdef CONV_SINAL_EN
   ,
   output logic               sinal_negativo
`endif
);

   localparam int unsigned LARG_CONT = $clog2(LARGURA + 1);
   localparam int unsigned LARG_ACC  = 4 * N_DIGITOS;

   estado_t                estado_q, estado_d;
   logic [LARG_ACC-1:0]    acc_q, acc_d, acc_ajustado;
   logic [LARGURA-1:0]     desloc_q, desloc_d, magnitude;
   logic [LARG_CONT-1:0]   contador_q, contador_d;
   logic                   atualiza;
   logic                   pronto_q;
   digito_t                centena_q, dezena_q, unidade_q;

   for (genvar i = 0; i < N_DIGITOS; i++) begin : g_ajuste
      ajuste_bcd_digito u_ajuste (
         .entrada (acc_q[4*i +: 4]),
         .saida   (acc_ajustado[4*i +: 4])
      );
   end

`ifdef CONV_SINAL_EN
   logic sinal_q, sinal_d, sinal_out_q;

   // Two's-complement negation; the most negative value wraps to its unsigned magnitude.
   assign magnitude = valor_binario[LARGURA-1] ? (~valor_binario + 1'b1) : valor_binario;
   assign sinal_d   = (estado_q == OCIOSO && inicio) ? valor_binario[LARGURA-1] : sinal_q;
   assign sinal_negativo = sinal_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinal_q     <= 1'b0;
         sinal_out_q <= 1'b0;
      end else begin
         sinal_q <= sinal_d;
         if (atualiza) begin
            sinal_out_q <= sinal_q;
         end
      end
   end
`else
   assign magnitude = valor_binario;
`endif

   always_comb begin
      estado_d   = estado_q;
      acc_d      = acc_q;
      desloc_d   = desloc_q;
      contador_d = contador_q;
      atualiza   = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (inicio) begin
               desloc_d   = magnitude;
               acc_d      = '0;
               contador_d = LARG_CONT'(LARGURA);
               estado_d   = DESLOCA;
            end
         end
         DESLOCA: begin
            // Correct first, then shift the whole {accumulator, operand} pair.
            {acc_d, desloc_d} = {acc_ajustado, desloc_q} << 1;
            contador_d        = contador_q - LARG_CONT'(1);
            if (contador_q == LARG_CONT'(1)) begin
               estado_d = FIM;
            end
         end
         FIM: begin
            atualiza = 1'b1;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= OCIOSO;
         acc_q      <= '0;
         desloc_q   <= '0;
         contador_q <= '0;
         pronto_q   <= 1'b0;
         centena_q  <= '0;
         dezena_q   <= '0;
         unidade_q  <= '0;
      end else begin
         estado_q   <= estado_d;
         acc_q      <= acc_d;
         desloc_q   <= desloc_d;
         contador_q <= contador_d;
         pronto_q   <= atualiza;
         if (atualiza) begin
            centena_q <= acc_q[11:8];
            dezena_q  <= acc_q[7:4];
            unidade_q <= acc_q[3:0];
         end
      end
   end

   assign ocupado     = (estado_q != OCIOSO);
   assign pronto      = pronto_q;
   assign centena_out = centena_q;
   assign dezena_out  = dezena_q;
   assign unidade_out = unidade_q;

endmodule
